// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state and owner encodings for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_mux2to1.sv
// rtl/mem_port_arbiter_mux2to1.sv - generic 2:1 mux used for the memory address path
module mux2to1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] D1,
  input  logic [W-1:0] D2,
  input  logic         Sel,
  output logic [W-1:0] Dout
);

  assign Dout = Sel ? D2 : D1;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch (I) and load/store (D)
// Define ARB_RR_EN for round-robin on contention; default is fixed D-over-I priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  output logic          IAck,
  output logic [DW-1:0] IRdata,
  input  logic          DReq,
  input  logic          DWe,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWdata,
  output logic          DAck,
  output logic [DW-1:0] DRdata,
  output logic          MemSel,
  output logic          MemEn,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWdata,
  input  logic [DW-1:0] MemRdata,
  output logic          Busy
);

  localparam int CW = (MEM_LAT + 1 > 1) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [CW-1:0] ACK_PRE = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] ACK_CNT = CW'(MEM_LAT);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic          winner;
  logic          any_req;

  assign any_req = IReq | DReq;

`ifdef ARB_RR_EN
  logic last_owner;

  always_comb begin
    winner = SEL_I;
    if (DReq && IReq) winner = (last_owner == SEL_I) ? SEL_D : SEL_I;
    else if (DReq)    winner = SEL_D;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                         last_owner <= SEL_I;
    else if (state == ST_IDLE && any_req) last_owner <= winner;
  end
`else
  assign winner = DReq ? SEL_D : SEL_I;
`endif

  // Acks are registered one cycle early so they land exactly when cnt == MEM_LAT.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      MemSel <= SEL_I;
      MemEn  <= 1'b0;
      MemWe  <= 1'b0;
      IAck   <= 1'b0;
      DAck   <= 1'b0;
      we_q   <= 1'b0;
    end else begin
      MemEn <= 1'b0;
      MemWe <= 1'b0;
      IAck  <= 1'b0;
      DAck  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state  <= ST_ACCESS;
            cnt    <= '0;
            MemSel <= winner;
            MemEn  <= 1'b1;
            MemWe  <= (winner == SEL_D) & DWe;
            we_q   <= (winner == SEL_D) & DWe;
          end
        end
        ST_ACCESS: begin
          if (cnt == ACK_PRE) begin
            IAck <= (MemSel == SEL_I);
            DAck <= (MemSel == SEL_D);
          end
          if (cnt == ACK_CNT) state <= ST_IDLE;
          else                cnt   <= cnt + CW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy     = (state == ST_ACCESS);
  assign IRdata   = IAck ? MemRdata : '0;
  assign DRdata   = (DAck && !we_q) ? MemRdata : '0;
  assign MemWdata = DWdata;

  mux2to1 #(.W(AW)) u_addr_mux (
    .D1   (IAddr),
    .D2   (DAddr),
    .Sel  (MemSel),
    .Dout (MemAddr)
  );

endmodule
